qupls_beb_queue: RTL and testbench

QUPLS_BEB_QUEUE -- requirements
Module: qupls_beb_queue

---
 rtl/qupls_beb_queue_pkg.sv | 37 +++
 rtl/qupls_beb_queue.sv | 102 ++++++++++
 tb/tb_qupls_beb_queue.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qupls_beb_queue_pkg.sv
// Shared Qupls types for the branch-execute buffer (BEB): deferred memory-op entries,
// checkpoint indexes and BEB slot indexes.
package QuplsPkg;

  localparam int BEB_ENTRIES  = 8;
  localparam int NCHECKPOINTS = 8;

  typedef logic [31:0] value_t;
  typedef logic [31:0] pc_address_t;
  typedef logic [31:0] instruction_t;
  typedef logic [8:0]  pregno_t;
  typedef logic [$clog2(NCHECKPOINTS)-1:0] checkpt_ndx_t;

  // Sized for the deepest supported queue (16 slots) so any depth fits.
  typedef logic [3:0] beb_ndx_t;

  typedef struct packed {
    logic       load;
    logic       store;
    logic [1:0] memsz;
    logic [11:0] misc;
  } decode_bus_t;

  typedef struct packed {
    value_t       argA;
    value_t       argB;
    value_t       argM;
    decode_bus_t  decbus;
    instruction_t op;
    pc_address_t  pc;
    checkpt_ndx_t cndx;
    logic         excv;
    pregno_t      pRc;
    logic         argC_v;
  } beb_entry_t;

endpackage

// File: rtl/qupls_beb_queue.sv
// Circular queue of deferred memory ops feeding the agen station whenever the ROB
// is not issuing to it; entries belonging to a flushed checkpoint are reclaimed unissued.
module qupls_beb_queue
  import QuplsPkg::*;
#(
  parameter int BEB_ENTRIES = QuplsPkg::BEB_ENTRIES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enq,
  input  beb_entry_t                    enq_entry,
  input  logic                          agen_idle,
  input  logic                          rob_issue,
  input  logic                          flush,
  input  checkpt_ndx_t                  flush_cndx,
  output logic                          beb_issue,
  output beb_ndx_t                      bndx,
  output beb_entry_t                    beb,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(BEB_ENTRIES):0]  count,
  output logic                          ovf
);

  localparam int NdxW = $clog2(BEB_ENTRIES);
  localparam int CntW = NdxW + 1;

  logic [NdxW-1:0]        head;
  logic [NdxW-1:0]        tail;
  beb_entry_t             slots [BEB_ENTRIES];
  logic [BEB_ENTRIES-1:0] slotValid;
  logic [BEB_ENTRIES-1:0] validNext;
  logic [CntW-1:0]        countNext;
  logic                   headValid;
  logic                   headFlushed;
  logic                   reclaim;
  logic                   deq;
  logic                   doEnq;

  assign empty       = (count == '0);
  assign full        = (count == CntW'(BEB_ENTRIES));
  assign headValid   = slotValid[head];
  assign headFlushed = flush && (slots[head].cndx == flush_cndx);

  // The ROB owns the station when it issues, so the queue only fills idle cycles.
  assign beb_issue = !empty && headValid && agen_idle && !rob_issue && !headFlushed;
  assign reclaim   = !empty && !headValid;
  assign deq       = beb_issue || reclaim;
  assign doEnq     = enq && !full;

  assign bndx = beb_ndx_t'(head);
  assign beb  = empty ? '0 : slots[head];

  always_comb begin
    countNext = count;
    if (doEnq && !deq)
      countNext = count + CntW'(1);
    else if (!doEnq && deq)
      countNext = count - CntW'(1);
  end

  // Flush only kills validity; slots stay allocated until head walks over them.
  always_comb begin
    validNext = slotValid;
    if (flush) begin
      for (int i = 0; i < BEB_ENTRIES; i++) begin
        if (slots[i].cndx == flush_cndx)
          validNext[i] = 1'b0;
      end
    end
    if (deq)
      validNext[head] = 1'b0;
    if (doEnq)
      validNext[tail] = !(flush && (enq_entry.cndx == flush_cndx));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      slotValid <= '0;
      ovf       <= 1'b0;
    end else begin
      if (deq)
        head <= head + NdxW'(1);
      if (doEnq)
        tail <= tail + NdxW'(1);
      count     <= countNext;
      slotValid <= validNext;
      if (enq && full)
        ovf <= 1'b1;
    end
  end

  // Payload storage needs no reset; validity and empty gate everything visible.
  always_ff @(posedge clk) begin
    if (doEnq)
      slots[tail] <= enq_entry;
  end

endmodule

// File: tb/tb_qupls_beb_queue.sv
// Randomized and directed checks of qupls_beb_queue against a queue-based reference model.
module tb_qupls_beb_queue;
  import QuplsPkg::*;

  localparam int N = 8;

  logic                clk;
  logic                rst;
  logic                enq;
  beb_entry_t          enq_entry;
  logic                agen_idle;
  logic                rob_issue;
  logic                flush;
  checkpt_ndx_t        flush_cndx;
  logic                beb_issue;
  beb_ndx_t            bndx;
  beb_entry_t          beb;
  logic                full;
  logic                empty;
  logic [$clog2(N):0]  count;
  logic                ovf;

  qupls_beb_queue #(.BEB_ENTRIES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .enq        (enq),
    .enq_entry  (enq_entry),
    .agen_idle  (agen_idle),
    .rob_issue  (rob_issue),
    .flush      (flush),
    .flush_cndx (flush_cndx),
    .beb_issue  (beb_issue),
    .bndx       (bndx),
    .beb        (beb),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .ovf        (ovf)
  );

  typedef struct {
    beb_entry_t e;
    bit         v;
    int         slot;
  } modelEntry_t;

  modelEntry_t modelQ[$];
  int          modelTail;
  bit          modelOvf;
  int          testsRun;
  int          failCount;
  int          issued;
  beb_entry_t  zeroEntry;
  bit          rEnq, rIdle, rRob, rFlush;
  checkpt_ndx_t rCndx, rFc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic beb_entry_t makeEntry(input logic [31:0] pc, input checkpt_ndx_t cn);
    beb_entry_t ent;
    ent.argA   = $urandom();
    ent.argB   = $urandom();
    ent.argM   = $urandom();
    ent.decbus = decode_bus_t'(16'($urandom()));
    ent.op     = $urandom();
    ent.pc     = pc;
    ent.cndx   = cn;
    ent.excv   = 1'($urandom_range(0, 1));
    ent.pRc    = pregno_t'($urandom_range(0, 511));
    ent.argC_v = 1'($urandom_range(0, 1));
    return ent;
  endfunction

  function automatic void modelReset();
    modelQ.delete();
    modelTail = 0;
    modelOvf  = 1'b0;
  endfunction

  // Drive one cycle, compare outputs against the model, then advance the model.
  task automatic applyStimulus(input bit e, input beb_entry_t ent, input bit idle,
                               input bit ri, input bit fl, input checkpt_ndx_t fc);
    bit expIssue;
    bit wasFull;
    modelEntry_t me;
    @(negedge clk);
    enq = e; enq_entry = ent; agen_idle = idle; rob_issue = ri; flush = fl; flush_cndx = fc;
    #1;
    wasFull  = (modelQ.size() == N);
    expIssue = (modelQ.size() > 0) && modelQ[0].v && idle && !ri &&
               !(fl && modelQ[0].e.cndx == fc);
    checkOutput("count", 256'(count), 256'(modelQ.size()));
    checkOutput("empty", 256'(empty), 256'(modelQ.size() == 0));
    checkOutput("full", 256'(full), 256'(wasFull));
    checkOutput("ovf", 256'(ovf), 256'(modelOvf));
    checkOutput("bebIssue", 256'(beb_issue), 256'(expIssue));
    if (modelQ.size() > 0) begin
      checkOutput("bndx", 256'(bndx), 256'(modelQ[0].slot));
      checkOutput("bebHead", 256'(beb), 256'(modelQ[0].e));
    end else begin
      checkOutput("bebZero", 256'(beb), 256'(0));
    end
    if (modelQ.size() > 0 && (expIssue || !modelQ[0].v))
      void'(modelQ.pop_front());
    if (fl) begin
      foreach (modelQ[i])
        if (modelQ[i].e.cndx == fc) modelQ[i].v = 1'b0;
    end
    if (e) begin
      if (!wasFull) begin
        me.e = ent;
        me.v = !(fl && ent.cndx == fc);
        me.slot = modelTail;
        modelQ.push_back(me);
        modelTail = (modelTail + 1) % N;
      end else begin
        modelOvf = 1'b1;
      end
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b0; enq = 1'b0; agen_idle = 1'b1; rob_issue = 1'b0; flush = 1'b0;
    #1;
    checkOutput("rstCount", 256'(count), 256'(0));
    checkOutput("rstEmpty", 256'(empty), 256'(1));
    checkOutput("rstFull", 256'(full), 256'(0));
    checkOutput("rstIssue", 256'(beb_issue), 256'(0));
    checkOutput("rstBndx", 256'(bndx), 256'(0));
    checkOutput("rstOvf", 256'(ovf), 256'(0));
    checkOutput("rstBeb", 256'(beb), 256'(0));
    @(posedge clk);
    #2;
    rst = 1'b1;
    modelReset();
  endtask

  initial begin
    testsRun = 0; failCount = 0; zeroEntry = '0;
    rst = 1'b0; enq = 1'b0; enq_entry = '0; agen_idle = 1'b0; rob_issue = 1'b0;
    flush = 1'b0; flush_cndx = '0;
    modelReset();
    applyReset();

    // In-order issue of three entries.
    for (int i = 0; i < 3; i++) applyStimulus(1, makeEntry(32'h100 + 4 * i, 0), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, zeroEntry, 1, 0, 0, 0);
      checkOutput("r33Issue", 256'(beb_issue), 256'(1));
      checkOutput("r33Bndx", 256'(bndx), 256'(i));
      checkOutput("r33Pc", 256'(beb.pc), 256'(32'h100 + 4 * i));
    end
    applyStimulus(0, zeroEntry, 1, 0, 0, 0);
    checkOutput("r33Empty", 256'(empty), 256'(1));

    // Overflow on the ninth enqueue; the dropped entry never appears.
    applyReset();
    for (int i = 0; i < 8; i++) applyStimulus(1, makeEntry(32'h200 + 4 * i, 1), 0, 0, 0, 0);
    applyStimulus(1, makeEntry(32'h900, 1), 0, 0, 0, 0);
    applyStimulus(0, zeroEntry, 0, 0, 0, 0);
    checkOutput("r34Full", 256'(full), 256'(1));
    checkOutput("r34Ovf", 256'(ovf), 256'(1));
    checkOutput("r34Count", 256'(count), 256'(8));
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, zeroEntry, 1, 0, 0, 0);
      checkOutput("r34No9th", 256'(beb_issue && beb.pc == 32'h900), 256'(0));
    end

    // ROB priority holds off the head for two cycles.
    applyReset();
    applyStimulus(1, makeEntry(32'h300, 0), 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, zeroEntry, 1, 1, 0, 0);
      checkOutput("r35Blocked", 256'(beb_issue), 256'(0));
    end
    applyStimulus(0, zeroEntry, 1, 0, 0, 0);
    checkOutput("r35Issue", 256'(beb_issue), 256'(1));

    // Checkpoint flush kills the cndx 2 entries.
    applyReset();
    applyStimulus(1, makeEntry(32'h400, 2), 0, 0, 0, 0);
    applyStimulus(1, makeEntry(32'h404, 3), 0, 0, 0, 0);
    applyStimulus(1, makeEntry(32'h408, 2), 0, 0, 0, 0);
    applyStimulus(1, makeEntry(32'h40c, 4), 0, 0, 0, 0);
    applyStimulus(0, zeroEntry, 0, 0, 1, 2);
    issued = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, zeroEntry, 1, 0, 0, 0);
      if (i == 0) checkOutput("r36CountHeld", 256'(count), 256'(4));
      if (beb_issue) begin
        issued++;
        checkOutput("r36Cndx", 256'(beb.cndx == 2), 256'(0));
      end
    end
    applyStimulus(0, zeroEntry, 1, 0, 0, 0);
    checkOutput("r36Count", 256'(count), 256'(0));
    checkOutput("r36Issued", 256'(issued), 256'(2));

    // Pointer wrap-around.
    applyReset();
    for (int i = 0; i < 8; i++) applyStimulus(1, makeEntry(32'h500 + 4 * i, 5), 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, zeroEntry, 1, 0, 0, 0);
    applyStimulus(1, makeEntry(32'h600, 5), 0, 0, 0, 0);
    applyStimulus(1, makeEntry(32'h604, 5), 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, zeroEntry, 1, 0, 0, 0);
      checkOutput("r37Issue", 256'(beb_issue), 256'(1));
      checkOutput("r37Bndx", 256'(bndx), 256'(i));
    end

    // Reset mid-operation discards everything.
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, makeEntry(32'h700 + 4 * i, 6), 0, 0, 0, 0);
    applyStimulus(0, zeroEntry, 0, 0, 0, 0);
    checkOutput("r38Count5", 256'(count), 256'(5));
    applyReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, zeroEntry, 1, 0, 0, 0);
      checkOutput("r38NoIssue", 256'(beb_issue), 256'(0));
    end

    // Random traffic with flushes and ROB contention.
    applyReset();
    for (int k = 0; k < 400; k++) begin
      rEnq   = ($urandom_range(0, 9) < 6);
      rIdle  = ($urandom_range(0, 9) < 7);
      rRob   = ($urandom_range(0, 9) < 3);
      rFlush = ($urandom_range(0, 7) == 0);
      rCndx  = checkpt_ndx_t'($urandom_range(0, 3));
      rFc    = checkpt_ndx_t'($urandom_range(0, 3));
      applyStimulus(rEnq, makeEntry(32'h1000 + 4 * k, rCndx), rIdle, rRob, rFlush, rFc);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
